instr_fetch_unit: RTL and testbench

// - Fetch stage upstream of the main decoder. Holds the PC and issues word reads to instruction memory over a req/ready + rvalid handshake.
// - Buffers returned instructions in a 2-entry FIFO and presents them as instr/op/pc to decode with a valid/ready handshake.
// - Accepts branch redirects (beq taken) and flushes all wrong-path instructions.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, one outstanding imem read, 2-entry buffer feeding decode (accept N, rvalid N+k, instr_valid N+k+1).
// Backpressure: instr_ready low fills the buffer, and no new read is issued while both slots are held.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ready,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
);

  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_pc, req_pc_nxt;
  logic            discard, discard_nxt;
  logic            push;
  logic            pop;
  logic            accept;
  logic [XLEN-1:0] target_pc;

  logic [XLEN-1:0] buf_instr [2];
  logic [XLEN-1:0] buf_pc    [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;

  assign target_pc   = pc_target & ALIGN_MASK;
  assign imem_req    = (state == S_REQ) && (count != 2'd2);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // Head is presented straight from the buffer; zeroed when empty so op idles at 0.
  assign instr    = instr_valid ? buf_instr[rd_ptr] : '0;
  assign pc_out   = instr_valid ? buf_pc[rd_ptr] : '0;
  assign op       = instr[6:0];
  assign pc_plus4 = pc_out + WORD_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      discard  <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    discard_nxt  = discard;
    push         = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (accept) begin
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + WORD_STEP;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push        = !discard;
          discard_nxt = 1'b0;
          state_nxt   = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A redirect overrides everything; a read still in flight is marked to be dropped on return.
    if (pc_src) begin
      fetch_pc_nxt = target_pc;
      push         = 1'b0;
      if (((state == S_WAIT) && !imem_rvalid) || accept) begin
        discard_nxt = 1'b1;
        state_nxt   = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (pc_src) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]    <= req_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/decode timing against an in-order instruction-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_ready = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = '0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .op          (op),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_ready (instr_ready),
    .pc_src      (pc_src),
    .pc_target   (pc_target)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int mem_pct = 100;
  int ird_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_dly;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_p4_q[$];
  logic [31:0] pop_ins_q[$];
  int          cyc;
  int          first_acc;
  int          first_vld;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2083;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic apply_reset();
    reset       = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = '0;
    pend        = 1'b0;
    exp_pc      = RESET_PC;
    exp_req     = RESET_PC;
    acc_q.delete();
    pop_pc_q.delete();
    pop_p4_q.delete();
    pop_ins_q.delete();
    cyc         = 0;
    first_acc   = -1;
    first_vld   = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock of memory responder, decode sink and stream model; entered and left at posedge+1.
  task automatic cycle(input bit redir, input logic [31:0] tgt);
    logic [31:0] mw;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pend_dly == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    imem_ready  = (int'($urandom_range(0, 99)) < mem_pct);
    instr_ready = (int'($urandom_range(0, 99)) < ird_pct);
    pc_src      = redir;
    pc_target   = tgt;

    if (!instr_valid) begin
      vectors++;
      if (op !== 7'b0) begin
        miscompares++;
        $display("FAIL empty_op: op=%b required 0000000 while instr_valid=0", op);
      end
    end
    if (instr_valid && first_vld < 0) first_vld = cyc;
    if (imem_req && pend) begin
      vectors++;
      miscompares++;
      $display("FAIL one_outstanding: imem_req=1 at %h with read to %h still pending", imem_addr, pend_addr);
    end
    if (imem_req && imem_ready) begin
      vectors++;
      if (imem_addr !== exp_req) begin
        miscompares++;
        $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, exp_req);
      end
      acc_q.push_back(imem_addr);
      if (first_acc < 0) first_acc = cyc;
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_dly  = int'($urandom_range(lat_min, lat_max)) - 1;
      exp_req   = exp_req + 32'd4;
    end
    if (instr_valid && instr_ready && !redir) begin
      mw = mem_word(exp_pc);
      vectors++;
      if (pc_out !== exp_pc || instr !== mw || op !== mw[6:0] || pc_plus4 !== exp_pc + 32'd4) begin
        miscompares++;
        $display("FAIL pop: pc=%h instr=%h op=%b pc4=%h required pc=%h instr=%h op=%b pc4=%h",
                 pc_out, instr, op, pc_plus4, exp_pc, mw, mw[6:0], exp_pc + 32'd4);
      end
      pop_pc_q.push_back(pc_out);
      pop_p4_q.push_back(pc_plus4);
      pop_ins_q.push_back(instr);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_pc  = tgt & ~32'd3;
      exp_req = tgt & ~32'd3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL reset_fetch: req=%b addr=%h required 0 %h", imem_req, imem_addr, RESET_PC);
    end
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || op !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_head: valid=%b instr=%h op=%b required 0 0 0", instr_valid, instr, op);
    end
    vectors++;
    if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
      miscompares++;
      $display("FAIL reset_pc: pc_out=%h pc_plus4=%h required 0 4", pc_out, pc_plus4);
    end
    mem_pct = 0;
    cycle(1'b0, $urandom);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL idle_to_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    apply_reset();
    mem_pct = 100; ird_pct = 100; lat_min = 1; lat_max = 1;
    repeat (12) cycle(1'b0, $urandom);
    vectors++;
    if (acc_q.size() < 3) begin
      miscompares++;
      $display("FAIL basic_accepts: %0d accepts required >=3", acc_q.size());
    end else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8) begin
      miscompares++;
      $display("FAIL basic_addrs: %h %h %h required 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
    end
    vectors++;
    if (pop_ins_q.size() == 0) begin
      miscompares++;
      $display("FAIL basic_op: no instruction delivered, required op 0000011");
    end else begin
      w = pop_ins_q[0];
      if (w[6:0] !== 7'b0000011) begin
        miscompares++;
        $display("FAIL basic_op: op=%b required 0000011", w[6:0]);
      end
    end
    vectors++;
    if (first_vld - first_acc != 2) begin
      miscompares++;
      $display("FAIL latency: accept->valid=%0d cycles required 2", first_vld - first_acc);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_pct = 100; ird_pct = 0; lat_min = 1; lat_max = 1;
    repeat (10) cycle(1'b0, $urandom);
    vectors++;
    if (acc_q.size() != 2) begin
      miscompares++;
      $display("FAIL bp_fetch_count: %0d fetches required 2", acc_q.size());
    end
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: req=%b valid=%b required 0 1", imem_req, instr_valid);
    end
    ird_pct = 100;
    repeat (6) cycle(1'b0, $urandom);
    vectors++;
    if (pop_pc_q.size() < 2) begin
      miscompares++;
      $display("FAIL bp_release: %0d pops required >=2", pop_pc_q.size());
    end else if (pop_pc_q[0] !== 32'h0 || pop_pc_q[1] !== 32'h4) begin
      miscompares++;
      $display("FAIL bp_order: %h %h required 0 4", pop_pc_q[0], pop_pc_q[1]);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    apply_reset();
    mem_pct = 100; ird_pct = 100; lat_min = 3; lat_max = 3;
    n = 0;
    while (!pend && n < 20) begin
      cycle(1'b0, $urandom);
      n++;
    end
    vectors++;
    if (!pend) begin
      miscompares++;
      $display("FAIL rw_wait_timeout: no request accepted within 20 cycles, required one");
    end
    cycle(1'b1, 32'h0000_0103);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rw_flush: instr_valid=%b required 0", instr_valid);
    end
    acc_q.delete();
    pop_pc_q.delete();
    n = 0;
    while (acc_q.size() == 0 && n < 20) begin
      cycle(1'b0, $urandom);
      n++;
    end
    vectors++;
    if (acc_q.size() == 0 || acc_q[0] !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL rw_next_addr: %0d accepts, first=%h required 00000100",
               acc_q.size(), (acc_q.size() != 0) ? acc_q[0] : 32'hx);
    end
    repeat (8) cycle(1'b0, $urandom);
    vectors++;
    if (pop_pc_q.size() == 0 || pop_pc_q[0] !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL rw_first_pop: %0d pops, first pc=%h required 00000100",
               pop_pc_q.size(), (pop_pc_q.size() != 0) ? pop_pc_q[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int n;
    bit hit;
    apply_reset();
    mem_pct = 100; ird_pct = 0; lat_min = 1; lat_max = 1;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 30) begin
      if (pend && pend_dly == 0 && instr_valid) begin
        ird_pct = 100;
        cycle(1'b1, 32'h0000_0200);
        hit = 1'b1;
      end else begin
        cycle(1'b0, $urandom);
      end
      n++;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rs_setup_timeout: rvalid with count=1 not seen in 30 cycles, required it");
    end
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rs_flush: instr_valid=%b required 0", instr_valid);
    end
    acc_q.delete();
    pop_pc_q.delete();
    repeat (10) cycle(1'b0, $urandom);
    vectors++;
    if (acc_q.size() == 0 || acc_q[0] !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL rs_next_addr: %0d accepts, first=%h required 00000200",
               acc_q.size(), (acc_q.size() != 0) ? acc_q[0] : 32'hx);
    end
    vectors++;
    if (pop_pc_q.size() == 0 || pop_pc_q[0] !== 32'h0000_0200) begin
      miscompares++;
      $display("FAIL rs_first_pop: %0d pops, first pc=%h required 00000200",
               pop_pc_q.size(), (pop_pc_q.size() != 0) ? pop_pc_q[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    int idx;
    apply_reset();
    mem_pct = 100; ird_pct = 100; lat_min = 1; lat_max = 1;
    cycle(1'b1, 32'hFFFF_FFF8);
    repeat (12) cycle(1'b0, $urandom);
    vectors++;
    if (acc_q.size() < 3) begin
      miscompares++;
      $display("FAIL wrap_accepts: %0d accepts required >=3", acc_q.size());
    end else if (acc_q[0] !== 32'hFFFF_FFF8 || acc_q[1] !== 32'hFFFF_FFFC || acc_q[2] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addrs: %h %h %h required FFFFFFF8 FFFFFFFC 00000000", acc_q[0], acc_q[1], acc_q[2]);
    end
    idx = -1;
    foreach (pop_pc_q[i]) if (idx < 0 && pop_pc_q[i] == 32'hFFFF_FFFC) idx = i;
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL wrap_pc4: head FFFFFFFC never delivered, required it");
    end else if (pop_p4_q[idx] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc4: pc_plus4=%h required 00000000", pop_p4_q[idx]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    apply_reset();
    mem_pct = 100; ird_pct = 100; lat_min = 3; lat_max = 3;
    n = 0;
    while (!pend && n < 20) begin
      cycle(1'b0, $urandom);
      n++;
    end
    vectors++;
    if (!pend) begin
      miscompares++;
      $display("FAIL rm_wait_timeout: no request accepted within 20 cycles, required one");
    end
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL rm_async: req=%b valid=%b addr=%h required 0 0 %h", imem_req, instr_valid, imem_addr, RESET_PC);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL rm_late_rvalid: valid=%b req=%b addr=%h required 0 1 %h", instr_valid, imem_req, imem_addr, RESET_PC);
    end
    imem_rvalid = 1'b0;
    pend = 1'b0;
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    pop_pc_q.delete();
    repeat (12) cycle(1'b0, $urandom);
    vectors++;
    if (pop_pc_q.size() == 0 || pop_pc_q[0] !== RESET_PC) begin
      miscompares++;
      $display("FAIL rm_restart: %0d pops, first pc=%h required %h",
               pop_pc_q.size(), (pop_pc_q.size() != 0) ? pop_pc_q[0] : 32'hx, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit redir;
    apply_reset();
    mem_pct = 70; ird_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      redir = (int'($urandom_range(0, 99)) < 4);
      cycle(redir, $urandom);
    end
    vectors++;
    if (pop_pc_q.size() < 100) begin
      miscompares++;
      $display("FAIL random_progress: %0d instructions delivered, required >=100", pop_pc_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
